dbus_mem_resp: RTL



---
 rtl/dbus_mem_resp.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dbus_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dbus_mem_resp
// Description : Multi-cycle data-bus responder with RV32I load/store sizing,
//               sign/zero extension and misalign / range error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_mem_resp #(
    parameter int BIT_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [2:0]           i_fun3,
    input  logic [BIT_WIDTH-1:0] i_addr,
    input  logic [BIT_WIDTH-1:0] i_wdata,
    output logic                 o_busy,
    output logic                 o_ack,
    output logic                 o_err,
    output logic [BIT_WIDTH-1:0] o_rdata
);

    localparam int                   c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]           c_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [BIT_WIDTH-1:0] c_DEPTH = BIT_WIDTH'(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [3:0]           r_cnt;
    logic                 r_we;
    logic [2:0]           r_fun3;
    logic [BIT_WIDTH-1:0] r_addr;
    logic [BIT_WIDTH-1:0] r_wdata;
    logic                 r_ack;
    logic                 r_err;
    logic [BIT_WIDTH-1:0] r_rdata;
    logic [BIT_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                 w_capture;
    logic                 w_access;
    logic                 w_acc_we;
    logic [2:0]           w_acc_fun3;
    logic [BIT_WIDTH-1:0] w_acc_addr;
    logic [BIT_WIDTH-1:0] w_acc_wdata;
    logic                 w_bad_f3;
    logic                 w_misalign;
    logic                 w_oob;
    logic                 w_err;
    logic [c_IDX_W-1:0]   w_idx;
    logic [BIT_WIDTH-1:0] w_rword;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [BIT_WIDTH-1:0] w_load;
    logic [3:0]           w_be;
    logic [BIT_WIDTH-1:0] w_wlanes;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req) w_next = (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_capture = (r_state == S_IDLE) && i_req;
        w_access  = (w_capture && (c_WAIT == 4'd0)) ||
                    ((r_state == S_WAIT) && (r_cnt <= 4'd1));
    end

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_fun3  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_cnt   <= c_WAIT;
            r_we    <= i_we;
            r_fun3  <= i_fun3;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // With zero wait states the access happens on the capture edge itself,
    // so the live inputs are used instead of the not-yet-loaded registers.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_we    = i_we;
            w_acc_fun3  = i_fun3;
            w_acc_addr  = i_addr;
            w_acc_wdata = i_wdata;
        end else begin
            w_acc_we    = r_we;
            w_acc_fun3  = r_fun3;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
        end
    end

    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        case (w_acc_fun3)
            3'b000: w_misalign = 1'b0;
            3'b001: w_misalign = w_acc_addr[0];
            3'b010: w_misalign = |w_acc_addr[1:0];
            3'b100: w_bad_f3   = w_acc_we;
            3'b101: begin
                w_bad_f3   = w_acc_we;
                w_misalign = w_acc_addr[0];
            end
            default: w_bad_f3 = 1'b1;
        endcase
        w_oob = ({2'b00, w_acc_addr[BIT_WIDTH-1:2]} >= c_DEPTH);
        w_err = w_bad_f3 | w_misalign | w_oob;
    end

    always_comb begin
        w_idx   = w_acc_addr[c_IDX_W+1:2];
        w_rword = r_mem[w_idx];
        w_byte  = w_rword[{w_acc_addr[1:0], 3'b000} +: 8];
        w_half  = w_acc_addr[1] ? w_rword[31:16] : w_rword[15:0];
        case (w_acc_fun3)
            3'b000:  w_load = {{(BIT_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(BIT_WIDTH-16){w_half[15]}}, w_half};
            3'b010:  w_load = w_rword;
            3'b100:  w_load = {{(BIT_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(BIT_WIDTH-16){1'b0}}, w_half};
            default: w_load = '0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        case (w_acc_fun3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << w_acc_addr[1:0];
                w_wlanes = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = w_acc_wdata;
            end
        endcase
    end

    // RAM is not reset; a write is suppressed while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (w_access && w_acc_we && !w_err && !i_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_access;
            r_err   <= w_access && w_err;
            r_rdata <= (w_access && !w_err && !w_acc_we) ? w_load : '0;
        end
    end

    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

endmodule
`default_nettype wire
